// File: rtl/alu_seq_pkg.sv
// Shared types and constants for alu_seq: ALU function codes, result FSM
// states and the command record stored in the command FIFO.
package alu_seq_pkg;

    localparam logic [2:0] F_ADD = 3'd0;
    localparam logic [2:0] F_SUB = 3'd1;
    localparam logic [2:0] F_AND = 3'd2;
    localparam logic [2:0] F_OR  = 3'd3;
    localparam logic [2:0] F_XOR = 3'd4;
    localparam logic [2:0] F_SLT = 3'd5;
    localparam logic [2:0] F_SLL = 3'd6;
    localparam logic [2:0] F_SRL = 3'd7;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  f;
    } cmd_t;

endpackage

// File: rtl/alu_seq_alu.sv
// Purely combinational 32-bit ALU; y and zero are not registered here.
module alu
    import alu_seq_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [2:0]  f,
    output logic [31:0] y,
    output logic        zero
);

    always_comb begin
        y = '0;
        case (f)
            F_ADD:   y = a + b;
            F_SUB:   y = a - b;
            F_AND:   y = a & b;
            F_OR:    y = a | b;
            F_XOR:   y = a ^ b;
            F_SLT:   y = {31'b0, $signed(a) < $signed(b)};
            F_SLL:   y = a << b[4:0];
            F_SRL:   y = a >> b[4:0];
            default: y = '0;
        endcase
    end

    assign zero = (y == '0);

endmodule

// File: rtl/alu_seq.sv
// Command FIFO feeding a combinational ALU, with a registered result stage
// under valid/ready handshake. Optional saturating zero-result counter
// is enabled by defining ALU_SEQ_ZERO_CNT_EN.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic [31:0]                cmd_a,
    input  logic [31:0]                cmd_b,
    input  logic [2:0]                 cmd_f,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [31:0]                rsp_y,
    output logic                       rsp_zero,
    output logic [$clog2(DEPTH):0]     fifo_count
`ifdef ALU_SEQ_ZERO_CNT_EN
    ,
    output logic [15:0]                zero_cnt
`endif
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    cmd_t           mem_q [DEPTH];
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  count_q, count_d;
    state_t         state_q, state_d;
    logic [31:0]    rsp_y_q, rsp_y_d;
    logic           rsp_zero_q, rsp_zero_d;
    cmd_t           head;
    logic [31:0]    alu_y;
    logic           alu_zero;
    logic           push, pop, empty;
`ifdef ALU_SEQ_ZERO_CNT_EN
    logic [15:0]    zero_cnt_q, zero_cnt_d;
`endif

    assign empty      = (count_q == '0);
    assign cmd_ready  = (count_q != CW'(DEPTH));
    assign head       = mem_q[rd_ptr_q];
    assign rsp_valid  = (state_q == HOLD);
    assign rsp_y      = rsp_y_q;
    assign rsp_zero   = rsp_zero_q;
    assign fifo_count = count_q;
`ifdef ALU_SEQ_ZERO_CNT_EN
    assign zero_cnt   = zero_cnt_q;
`endif

    alu u_alu (
        .a    (head.a),
        .b    (head.b),
        .f    (head.f),
        .y    (alu_y),
        .zero (alu_zero)
    );

    always_comb begin
        push       = cmd_valid && cmd_ready;
        // Head is consumed either to fill an empty result stage or to replace
        // a result the consumer is taking this cycle.
        pop        = !empty && ((state_q == IDLE) || rsp_ready);
        state_d    = state_q;
        rsp_y_d    = rsp_y_q;
        rsp_zero_d = rsp_zero_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;

        case (state_q)
            IDLE:    if (!empty) state_d = HOLD;
            HOLD:    if (rsp_ready && empty) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (pop) begin
            rsp_y_d    = alu_y;
            rsp_zero_d = alu_zero;
            rd_ptr_d   = rd_ptr_q + AW'(1);
        end
        if (push) wr_ptr_d = wr_ptr_q + AW'(1);

        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

`ifdef ALU_SEQ_ZERO_CNT_EN
        zero_cnt_d = zero_cnt_q;
        if ((state_q == HOLD) && rsp_ready && rsp_zero_q && (zero_cnt_q != 16'hFFFF))
            zero_cnt_d = zero_cnt_q + 16'd1;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            rsp_y_q    <= '0;
            rsp_zero_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
`ifdef ALU_SEQ_ZERO_CNT_EN
            zero_cnt_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            rsp_y_q    <= rsp_y_d;
            rsp_zero_q <= rsp_zero_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
`ifdef ALU_SEQ_ZERO_CNT_EN
            zero_cnt_q <= zero_cnt_d;
`endif
        end
    end

    // Storage needs no reset: entries are only read while count_q is non-zero.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= '{a: cmd_a, b: cmd_b, f: cmd_f};
    end

endmodule
